// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the multiplexed display driver.
// Encodings are written g..a (bit 0 = segment a) and are active-low.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Full 16-entry glyph lookup; BCD-only masking is applied by the caller.
  function automatic logic [6:0] seg_lookup(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = SEG_A;
      4'd11:   seg = SEG_B;
      4'd12:   seg = SEG_C;
      4'd13:   seg = SEG_D;
      4'd14:   seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational single-digit decoder: code -> active-low segment pattern.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg_n
);

  // Blanking wins; codes above 9 only render as letters in hex mode.
  always_comb begin
    if (blank) begin
      seg_n = SEG_BLANK;
    end else if ((code > 4'd9) && !hex_mode) begin
      seg_n = SEG_BLANK;
    end else begin
      seg_n = seg_lookup(code);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with tear-free double buffering.
// A new value is staged in the pending buffer and only promoted to the active
// buffer on the tick that wraps the scan back to digit 0.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     an_n,
  output logic                    upd_pend,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  wrap;

  logic [4*N_DIGITS-1:0] act_val;
  logic [N_DIGITS-1:0]   act_dp;
  logic [4*N_DIGITS-1:0] pend_val;
  logic [N_DIGITS-1:0]   pend_dp;

  logic [N_DIGITS-1:0]   lz_mask;
  logic                  zero_above;
  logic [3:0]            code_p0;
  logic                  dp_p0;
  logic                  blank_p0;
  logic [6:0]            seg_p0;

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(N_DIGITS - 1));

  // Prescaler and digit index; the index only moves on prescaler ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (wrap) begin
        idx <= '0;
      end else if (tick) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Double buffer: a load on the wrap tick still lands in pending, so the
  // active buffer takes the previous pending contents and upd_pend stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      upd_pend <= 1'b0;
    end else begin
      if (wrap && upd_pend) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        upd_pend <= 1'b1;
      end else if (wrap) begin
        upd_pend <= 1'b0;
      end
    end
  end

  // Leading-zero mask: digit i is blankable when it and every digit above it
  // are zero. Digit 0 is never included so "0" always shows.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (act_val[4*i +: 4] == 4'd0);
      lz_mask[i] = blank_lz && zero_above;
    end
  end

  // Select the digit currently being scanned from the active buffer.
  always_comb begin
    code_p0  = 4'd0;
    dp_p0    = 1'b0;
    blank_p0 = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        code_p0  = act_val[4*i +: 4];
        dp_p0    = act_dp[i];
        blank_p0 = lz_mask[i];
      end
    end
  end

  seg_decode u_decode (
    .code     (code_p0),
    .hex_mode (hex_mode),
    .blank    (blank_p0),
    .seg_n    (seg_p0)
  );

  // ---- stage p0 -> p1: registered pad outputs ----
  // Outputs follow the index and active buffer with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= ~(N_DIGITS'(1) << idx);
      seg_n      <= seg_p0;
      dp_n       <= ~dp_p0;
      frame_done <= wrap;
    end
  end

endmodule
